pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Owns the architectural PC register and fetches instructions for the single-cycle core.
//   Issues one instruction-memory request at a time with a valid/ready handshake.
//   Presents the returned word plus its PC to decode.
//   Loads the combinational next-PC value into the PC when decode accepts the instruction.
//   Sits between instruction memory and decode; pc feeds the next-PC logic and next_pc_in closes the loop.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   XLEN      32             address/data width
// PORTS
//   clk              in   1     single clock, rising edge
//   rst              in   1     synchronous, active-high reset
//   next_pc_in       in   XLEN  next PC from next-PC logic (valid while inst_valid)
//   pc               out  XLEN  current PC register
//   imem_req_valid   out  1     fetch request valid
//   imem_req_ready   in   1     memory accepts request
//   imem_req_addr    out  XLEN  fetch address (= pc)
//   imem_rsp_valid   in   1     read data valid (1-cycle pulse)
//   imem_rsp_data    in   XLEN  instruction word
//   inst_valid       out  1     instruction available to decode
//   inst_ready       in   1     decode/execute retires instruction this cycle
//   inst_out         out  XLEN  held instruction word
//   inst_pc          out  XLEN  PC of inst_out
//   fetch_misalign   out  1     1-cycle pulse: next_pc_in[1:0]!=0 on retire
//   inst_count       out  32    retired-instruction counter
//   halted           out  1     self-loop halt detected (HALT_DETECT_EN only)
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge):
//     pc=RESET_PC; state=S_REQ; inst_out=32'h0000_0013 (NOP); inst_valid=0;
//     inst_pc=RESET_PC; fetch_misalign=0; inst_count=0; halted=0.
//   imem_req_valid is combinational (state==S_REQ && !rst), so it is 0 while rst is high.
//   FSM states: S_REQ, S_WAIT, S_HOLD, S_HALT.
//     S_REQ:  imem_req_valid=1, addr=pc; addr is stable until accepted;
//             imem_req_valid&&imem_req_ready -> S_WAIT.
//     S_WAIT: on imem_rsp_valid, inst_out<=data, inst_pc<=pc, inst_valid<=1 -> S_HOLD.
//             Response latency >=1 cycle after accept; no timeout.
//     S_HOLD: inst_valid=1, outputs stable; on inst_ready (retire):
//             pc<={next_pc_in[31:2],2'b00}, inst_valid<=0, inst_count<=inst_count+1 (wraps mod 2^32);
//             if next_pc_in[1:0]!=0, fetch_misalign=1 for one cycle;
//             -> S_REQ, or S_HALT (see CONFIGURATION).
//     S_HALT: no requests; inst_valid=0; exit only via rst.
//   imem_rsp_valid outside S_WAIT is ignored.
//   Only one transaction is outstanding, so there is never more than one response in flight.
//   Throughput: at least 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory.
//   Reset mid-transaction: FSM returns to S_REQ; imem must share rst so no stale response arrives.
//   inst_ready while inst_valid=0 is ignored (pc and counter unchanged).
// CONFIGURATION
//   HALT_DETECT_EN defined:
//     retire with next_pc_in==pc -> halted<=1 next cycle, state S_HALT; pc and inst_count keep final values.
//   HALT_DETECT_EN undefined:
//     halted tied 0, S_HALT unreachable; a self-loop keeps refetching the same PC forever.
// STRUCTURE
//   Shared package riscv_pkg:
//     state typedef for S_REQ/S_WAIT/S_HOLD/S_HALT;
//     constants NOP_INST=32'h0000_0013 and RESET_PC_DEFAULT.
//   One sub-module: fetch_hold_reg (1-entry register for inst_out/inst_pc/inst_valid, load/clear).
//   FSM, PC register and counter stay in the top module.
// TESTING
//   1 Reset: rst=1 for 2 cycles -> pc=0, imem_req_valid=0, inst_valid=0, inst_count=0;
//     first request, addr 0, on the cycle after rst falls.
//   2 Sequential: zero-wait memory, inst_ready=1, next_pc_in=pc+4 ->
//     addrs 0,4,8 at 3-cycle spacing; inst_count=3 after third retire.
//   3 Backpressure: imem_req_ready=0 for 4 cycles, then inst_ready=0 for 5 cycles ->
//     addr and inst_out/inst_pc stable; pc unchanged until retire.
//   4 Branch and misalign: retire at pc=0x10 with next_pc_in=0x40 -> next addr 0x40;
//     next_pc_in=0x46 -> pc=0x44 and fetch_misalign pulses for 1 cycle.
//   5 Halt (HALT_DETECT_EN): pc=0x6c, next_pc_in=0x6c on retire -> halted=1, no further imem_req_valid;
//     without macro, 0x6c is refetched repeatedly.
//   6 Reset mid-op: rst asserted in S_HOLD at pc=0x20 -> next cycle pc=RESET_PC, inst_valid=0, inst_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types and constants shared by the instruction-fetch block and its bench.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry holding register presenting a fetched instruction and its PC to decode.
module fetch_hold_reg
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] load_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  // Clearing only drops valid; the word and PC stay visible for debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst_out   <= XLEN'(NOP_INST);
      inst_pc    <= RESET_PC;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst_out   <= load_data;
      inst_pc    <= load_pc;
    end else if (clear) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch FSM.
// Optional self-loop halt detection is enabled by defining HALT_DETECT_EN.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc_in,
  output logic [XLEN-1:0] pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misalign,
  output logic [31:0]     inst_count,
  output logic            halted
);

  fetch_state_t state, state_next;
  logic         rsp_load;
  logic         retire;
  logic         halt_hit;

  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign rsp_load       = (state == S_WAIT) && imem_rsp_valid;
  assign retire         = (state == S_HOLD) && inst_ready;

`ifdef HALT_DETECT_EN
  assign halt_hit = retire && (next_pc_in == pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (halt_hit) begin
      halted <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   if (imem_req_ready) state_next = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_next = S_HOLD;
      S_HOLD:  if (inst_ready) state_next = halt_hit ? S_HALT : S_REQ;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_REQ;
    endcase
  end

  // The low PC bits are dropped on retire; a nonzero pair is flagged for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      inst_count     <= 32'd0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_next;
      fetch_misalign <= retire && (next_pc_in[1:0] != 2'b00);
      if (retire) begin
        pc         <= {next_pc_in[XLEN-1:2], 2'b00};
        inst_count <= inst_count + 32'd1;
      end
    end
  end

  fetch_hold_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (rsp_load),
    .clear      (retire),
    .load_data  (imem_rsp_data),
    .load_pc    (pc),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch/retire sequences against a zero-wait memory model.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ret_t;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc_in;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_misalign;
  logic [31:0] inst_count;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_addr_q[$];
  ret_t        exp_ret_q[$];

  pc_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc_in     (next_pc_in),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_misalign (fetch_misalign),
    .inst_count     (inst_count),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hA500_0000 | addr;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at t=%0t", name, $time);
  endtask

  // Memory: accepts at the posedge after a visible handshake, answers one cycle later.
  initial begin : memory_model
    logic [31:0] addr_l;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        addr_l = imem_req_addr;
        @(posedge clk); #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memWord(addr_l);
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [31:0] ea;
    ret_t        er;
    if (!rst && imem_req_valid && imem_req_ready) begin
      if (exp_addr_q.size() == 0) reportFail("unexpected_request");
      else begin
        ea = exp_addr_q.pop_front();
        checkOutput("req_addr", imem_req_addr, ea);
      end
    end
    if (!rst && inst_valid && inst_ready) begin
      if (exp_ret_q.size() == 0) reportFail("unexpected_retire");
      else begin
        er = exp_ret_q.pop_front();
        checkOutput("retire_inst", inst_out, er.inst);
        checkOutput("retire_pc", inst_pc, er.pc);
      end
    end
  end

  // One full fetch/retire of addr with optional request and decode stalls; returns at posedge+1 after retire.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] npc,
                               input int req_stall, input int hold_stall);
    int n;
    exp_addr_q.push_back(addr);
    exp_ret_q.push_back('{inst: memWord(addr), pc: addr});
    next_pc_in     = npc;
    imem_req_ready = (req_stall == 0);
    inst_ready     = (hold_stall == 0);
    for (int k = 0; k < req_stall; k++) begin
      checkOutput("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("stall_req_addr", imem_req_addr, addr);
      checkOutput("stall_req_pc", pc, addr);
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b1;
    n = 0;
    while (!inst_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inst_valid) reportFail("inst_valid_timeout");
    for (int k = 0; k < hold_stall; k++) begin
      checkOutput("hold_valid", {31'd0, inst_valid}, 32'd1);
      checkOutput("hold_inst", inst_out, memWord(addr));
      checkOutput("hold_inst_pc", inst_pc, addr);
      checkOutput("hold_pc", pc, addr);
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int t0;
    int n;
    rst            = 1'b1;
    next_pc_in     = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;

    // Reset held for two cycles
    @(posedge clk); #1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rst_count", inst_count, 32'd0);
    checkOutput("rst_inst_out", inst_out, 32'h0000_0013);
    checkOutput("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);

    // Sequential zero-wait fetches at three-cycle spacing
    t0 = cyc;
    applyStimulus(32'h00, 32'h04, 0, 0);
    applyStimulus(32'h04, 32'h08, 0, 0);
    applyStimulus(32'h08, 32'h0c, 0, 0);
    checkOutput("seq_cycles", cyc - t0, 32'd9);
    checkOutput("seq_count", inst_count, 32'd3);
    checkOutput("seq_pc", pc, 32'h0c);

    // Backpressure on both handshakes
    applyStimulus(32'h0c, 32'h10, 4, 5);
    checkOutput("bp_pc", pc, 32'h10);
    checkOutput("bp_count", inst_count, 32'd4);

    // Branch then misaligned target
    applyStimulus(32'h10, 32'h40, 0, 0);
    checkOutput("branch_pc", pc, 32'h40);
    checkOutput("branch_misalign", {31'd0, fetch_misalign}, 32'd0);
    applyStimulus(32'h40, 32'h46, 0, 0);
    checkOutput("misalign_pc", pc, 32'h44);
    checkOutput("misalign_pulse", {31'd0, fetch_misalign}, 32'd1);
    @(posedge clk); #1;
    checkOutput("misalign_clear", {31'd0, fetch_misalign}, 32'd0);
    checkOutput("misalign_count", inst_count, 32'd6);

    // Reset while holding the instruction at 0x20
    applyStimulus(32'h44, 32'h20, 0, 0);
    checkOutput("pre_mid_pc", pc, 32'h20);
    exp_addr_q.push_back(32'h20);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inst_valid) reportFail("mid_inst_valid_timeout");
    checkOutput("mid_hold_pc", inst_pc, 32'h20);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_pc", pc, 32'h0);
    checkOutput("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("mid_rst_count", inst_count, 32'd0);
    checkOutput("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;

    // Self-loop at 0x6c
    applyStimulus(32'h00, 32'h6c, 0, 0);
    checkOutput("loop_pc", pc, 32'h6c);
`ifdef HALT_DETECT_EN
    applyStimulus(32'h6c, 32'h6c, 0, 0);
    checkOutput("halt_flag", {31'd0, halted}, 32'd1);
    checkOutput("halt_pc", pc, 32'h6c);
    checkOutput("halt_count", inst_count, 32'd2);
    imem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_req_ready = 1'b0;
`else
    applyStimulus(32'h6c, 32'h6c, 0, 0);
    applyStimulus(32'h6c, 32'h6c, 0, 0);
    checkOutput("loop_halted", {31'd0, halted}, 32'd0);
    checkOutput("loop_pc_again", pc, 32'h6c);
    checkOutput("loop_count", inst_count, 32'd3);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("addr_q_empty", exp_addr_q.size(), 32'd0);
    checkOutput("ret_q_empty", exp_ret_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
